// File: rtl/sub_32_bit_seq.sv
// Sequential N-bit two's-complement subtractor: one CHUNK-wide slice per clock,
// LSB slice first, with a registered borrow carried between slices.
module sub_32_bit_seq #(
  parameter int N     = 32,
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] input1,
  input  logic [N-1:0] input2,
  output logic         ready,
  output logic [N-1:0] answer,
  output logic         borrow_out,
  output logic         overflow,
  output logic         done
);

  localparam int NS = N / CHUNK;
  localparam int CW = (NS > 1) ? $clog2(NS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            brw_q, brw_d;
  logic [N-1:0]    ans_q, ans_d;
  logic            bo_q, bo_d;
  logic            ovf_q, ovf_d;
  logic [N-1:0]    a_q, b_q;
  logic [CHUNK:0]  slice_res;
  int              base;

  // Top bit of the (CHUNK+1)-bit result is the slice borrow-out.
  function automatic logic [CHUNK:0] slice_sub(input logic [CHUNK-1:0] a,
                                               input logic [CHUNK-1:0] b,
                                               input logic             bin);
    slice_sub = {1'b0, a} - {1'b0, b} - {{CHUNK{1'b0}}, bin};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      ans_q   <= '0;
      bo_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
      ans_q   <= ans_d;
      bo_q    <= bo_d;
      ovf_q   <= ovf_d;
    end
  end

  // Operand latches carry no reset; they are only read after an accepted start.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && start) begin
      a_q <= input1;
      b_q <= input2;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (cnt_q == CW'(NS - 1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    base      = int'(cnt_q) * CHUNK;
    slice_res = slice_sub(a_q[base +: CHUNK], b_q[base +: CHUNK], brw_q);
    cnt_d     = cnt_q;
    brw_d     = brw_q;
    ans_d     = ans_q;
    bo_d      = bo_q;
    ovf_d     = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d = '0;
          brw_d = 1'b0;
        end
      end
      S_RUN: begin
        ans_d[base +: CHUNK] = slice_res[CHUNK-1:0];
        brw_d                = slice_res[CHUNK];
        cnt_d                = cnt_q + 1'b1;
        if (cnt_q == CW'(NS - 1)) begin
          bo_d  = slice_res[CHUNK];
          ovf_d = (a_q[N-1] != b_q[N-1]) && (slice_res[CHUNK-1] != a_q[N-1]);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    ready      = (state_q == S_IDLE);
    done       = (state_q == S_DONE);
    answer     = ans_q;
    borrow_out = bo_q;
    overflow   = ovf_q;
  end

endmodule

// File: tb/tb_sub_32_bit_seq.sv
// Scoreboard bench for sub_32_bit_seq: stimulus pushes expected results,
// a negedge monitor pops and compares whenever done is high.
module tb_sub_32_bit_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] input1 = '0;
  logic [31:0] input2 = '0;
  logic        ready;
  logic [31:0] answer;
  logic        borrow_out;
  logic        overflow;
  logic        done;

  typedef struct {
    logic [31:0] ans;
    logic        bo;
    logic        ovf;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  logic chk_rst = 1'b0;
  logic prev_done = 1'b0;

  sub_32_bit_seq #(.N(32), .CHUNK(8)) dut (
    .clk(clk), .rst(rst), .start(start), .input1(input1), .input2(input2),
    .ready(ready), .answer(answer), .borrow_out(borrow_out),
    .overflow(overflow), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: the only process that steps the comparison counters.
  always @(negedge clk) begin
    if (chk_rst) begin
      chk("rst_ready", {31'd0, ready}, 32'd1);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_answer", answer, 32'd0);
      chk("rst_borrow", {31'd0, borrow_out}, 32'd0);
      chk("rst_overflow", {31'd0, overflow}, 32'd0);
    end
    if (done) begin
      chk("done_single_cycle", {31'd0, prev_done}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("answer", answer, e.ans);
        chk("borrow_out", {31'd0, borrow_out}, {31'd0, e.bo});
        chk("overflow", {31'd0, overflow}, {31'd0, e.ovf});
        chk("latency_cycle", cyc, e.due);
        chk("ready_in_done", {31'd0, ready}, 32'd0);
      end
    end
    prev_done = done;
  end

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input bit push,
                       input logic [31:0] ea, input logic ebo, input logic eovf);
    int w;
    exp_t e;
    w = 0;
    @(negedge clk);
    while (!ready) begin
      @(negedge clk);
      w++;
      if (w > 20) begin
        $display("FAIL ready_timeout: ready stuck low, expected high within 20 cycles");
        $fatal(1);
      end
    end
    start  = 1'b1;
    input1 = a;
    input2 = b;
    @(posedge clk);
    #1;
    start  = 1'b0;
    input1 = $urandom;
    input2 = $urandom;
    if (push) begin
      e.ans = ea; e.bo = ebo; e.ovf = eovf; e.due = cyc + 4;
      sb.push_back(e);
    end
  endtask

  task automatic ref_op(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] d;
    logic        v;
    d = {1'b0, a} - {1'b0, b};
    v = (a[31] != b[31]) && (d[31] != a[31]);
    do_op(a, b, 1'b1, d[31:0], d[32], v);
  endtask

  task automatic rst_window_check;
    chk_rst = 1'b1;
    @(negedge clk);
    #1;
    chk_rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w;
    repeat (2) @(posedge clk);
    #1;
    rst_window_check();
    @(posedge clk);
    #2 rst = 1'b0;
    rst_window_check();

    do_op(32'd10, 32'd3, 1'b1, 32'h0000_0007, 1'b0, 1'b0);
    do_op(32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    do_op(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1);
    do_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 1'b1, 1'b1);
    do_op(32'h0001_0000, 32'h0000_0001, 1'b1, 32'h0000_FFFF, 1'b0, 1'b0);

    // Start held high with other operands while RUN must be ignored.
    @(negedge clk);
    start  = 1'b1;
    input1 = 32'hDEAD_BEEF;
    input2 = 32'h1234_5678;
    @(negedge clk);
    @(negedge clk);
    start  = 1'b0;

    // Abort an operation in its second RUN cycle; no done may follow.
    do_op(32'hFFFF_0000, 32'h0000_1111, 1'b0, 32'd0, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    rst_window_check();
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (6) @(negedge clk);

    do_op(32'd5, 32'd5, 1'b1, 32'h0000_0000, 1'b0, 1'b0);
    do_op(32'h0000_0100, 32'h0000_0001, 1'b1, 32'h0000_00FF, 1'b0, 1'b0);
    do_op(32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b0);

    for (int i = 0; i < 300; i++) ref_op($urandom, $urandom);

    w = 0;
    while (sb.size() != 0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0) begin
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
      $fatal(1);
    end
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
